// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX path and its TX counterpart:
// frame FSM states, parity type encoding and default word size.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    localparam int UART_DATA_WIDTH = 8;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the UART receiver: edge counter over one bit period,
// three mid-bit samples of the line and their majority vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  start,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_done,
    output logic                  sample_valid,
    output logic                  sampled_bit
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [2:0]            smp_q, smp_d;
    logic [PRESCALE_W-1:0] half;
    logic                  last_edge;

    always_comb begin
        half      = prescale >> 1;
        last_edge = (cnt_q == prescale - 1'b1);
        bit_done  = en & last_edge;
        cnt_d     = cnt_q;
        smp_d     = smp_q;

        // The detection cycle is edge 0, so the count resumes at 1.
        if (start) begin
            cnt_d = {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end else if (en) begin
            cnt_d = last_edge ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end

        if (en) begin
            if (cnt_q == half - 1'b1) smp_d[0] = rx_in;
            if (cnt_q == half)        smp_d[1] = rx_in;
            if (cnt_q == half + 1'b1) smp_d[2] = rx_in;
        end

        sample_valid = en & (cnt_q >= half + PRESCALE_W'(2));
        sampled_bit  = majority3(smp_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            smp_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            smp_q <= smp_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detection, LSB-first deserialization, optional parity
// and stop checking, with registered one-cycle result strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_err_q, par_err_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  stop_error_q, stop_error_d;

    logic start_det;
    logic bit_done;
    logic sample_valid;
    logic sampled_bit;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk          (CLK),
        .rst_n        (RST),
        .en           (state_q != IDLE),
        .start        (start_det),
        .rx_in        (RX_IN),
        .prescale     (prescale_q),
        .bit_done     (bit_done),
        .sample_valid (sample_valid),
        .sampled_bit  (sampled_bit)
    );

    // An even prescale of at least 6 always has the vote settled by bit end.
    assert property (@(posedge CLK) disable iff (!RST) bit_done |-> sample_valid);

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        data_d         = data_q;
        prescale_d     = prescale_q;
        par_en_d       = par_en_q;
        par_typ_d      = par_typ_q;
        par_err_d      = par_err_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;
        start_det      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    start_det  = 1'b1;
                    prescale_d = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_err_d  = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    state_d   = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    par_err_d = sampled_bit != ((^shift_q) ^ (par_typ_q == ODD));
                    state_d   = STOP;
                end
            end
            STOP: begin
                // Returning to IDLE makes the strobe cycle a start-detect cycle,
                // so a back-to-back start bit is caught without a gap.
                if (bit_done) begin
                    stop_error_d   = !sampled_bit;
                    parity_error_d = par_err_q;
                    data_valid_d   = sampled_bit && !par_err_q;
                    if (data_valid_d) data_d = shift_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            data_q         <= '0;
            prescale_q     <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            par_err_q      <= 1'b0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            data_q         <= data_d;
            prescale_q     <= prescale_d;
            par_en_q       <= par_en_d;
            par_typ_q      <= par_typ_d;
            par_err_q      <= par_err_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    assign P_DATA       = data_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives whole frames bit by bit and compares every result
// strobe (time, kind, word) against a frame-level model of the receiver.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;

    uart_rx dut (
        .CLK          (clk),
        .RST          (rst),
        .RX_IN        (rx),
        .Prescale     (prescale),
        .PAR_EN       (par_en),
        .PAR_TYP      (par_typ),
        .P_DATA       (p_data),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error)
    );

    typedef struct {
        int         stamp;
        logic [2:0] flags;   // {data_valid, parity_error, stop_error}
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] last_good = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (data_valid | parity_error | stop_error)
            obs_q.push_back('{cyc, {data_valid, parity_error, stop_error}, p_data});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the stop bit.
    // abort_at > 0 stops driving at that bit index and expects nothing.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic ptyp, input logic flip_par,
                              input logic stop_bit, input logic glitch,
                              input int abort_at);
        logic       bits[12];
        int         nb;
        int         t0;
        int         gpos;
        logic       pbit;
        logic       pe, se, dv;
        pbit    = (^d) ^ ptyp ^ flip_par;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        nb = 9;
        if (pen) begin
            bits[nb] = pbit;
            nb = nb + 1;
        end
        bits[nb] = stop_bit;
        nb = nb + 1;
        t0 = cyc;
        for (int i = 0; i < nb; i++) begin
            if (abort_at > 0 && i == abort_at) return;
            gpos = p / 2 - 1 + int'($urandom_range(0, 2));
            for (int k = 0; k < p; k++) begin
                if (i == 0 && k == 0) begin
                    prescale = 6'(p);
                    par_en   = pen;
                    par_typ  = ptyp;
                end else if (i == 0 && k == 1) begin
                    prescale = 6'($urandom);
                    par_en   = 1'($urandom);
                    par_typ  = 1'($urandom);
                end
                rx = (glitch && k == gpos) ? ~bits[i] : bits[i];
                @(negedge clk);
            end
        end
        pe = pen && (pbit != ((^d) ^ ptyp));
        se = !stop_bit;
        dv = !pe && !se;
        if (dv) last_good = d;
        exp_q.push_back('{t0 + nb * p, {dv, pe, se}, last_good});
    endtask

    task automatic drain(input string tag);
        int n;
        rx = 1'b1;
        repeat (80) @(negedge clk);
        chk({tag, ".count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, ".stamp"}, obs_q[i].stamp, exp_q[i].stamp);
            chk({tag, ".flags"}, {29'd0, obs_q[i].flags}, {29'd0, exp_q[i].flags});
            chk({tag, ".data"},  {24'd0, obs_q[i].data},  {24'd0, exp_q[i].data});
        end
        chk({tag, ".pdata"}, {24'd0, p_data}, {24'd0, last_good});
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst      = 1'b0;
        rx       = 1'b1;
        prescale = 6'd16;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.pdata", {24'd0, p_data}, 32'd0);
        chk("rst.dv", {31'd0, data_valid}, 32'd0);
        chk("rst.pe", {31'd0, parity_error}, 32'd0);
        chk("rst.se", {31'd0, stop_error}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5, no parity: strobe 160 cycles after the start edge
        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        drain("a5");

        // even parity, wrong then right parity bit
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        drain("3c_bad");
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        drain("3c_ok");

        // odd parity, stop bit 0, then a full break frame, then immediate restart
        send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        send_frame(8'h00, 32, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h5A, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        drain("break");

        // start-bit glitch of 3 cycles must be ignored
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (48) @(negedge clk);
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        drain("glitch_start");

        // single-sample glitches, then back-to-back frames
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        send_frame(8'h12, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8'h34, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        drain("b2b");

        // reset in the middle of the data bits
        send_frame(8'h99, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        rst = 1'b0;
        #1;
        chk("midrst.pdata", {24'd0, p_data}, 32'd0);
        chk("midrst.dv", {31'd0, data_valid}, 32'd0);
        chk("midrst.pe", {31'd0, parity_error}, 32'd0);
        chk("midrst.se", {31'd0, stop_error}, 32'd0);
        rx = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_frame(8'hC3, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        drain("c3");

        // randomized frames, formats, errors, glitches and gaps
        for (int n = 0; n < 24; n++) begin
            int gap;
            send_frame(8'($urandom), 8 << $urandom_range(0, 2), 1'($urandom),
                       1'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 7) != 0), 1'($urandom), 0);
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
            if (gap > 0) begin
                rx = 1'b1;
                repeat (gap) @(negedge clk);
            end
        end
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
